// File: rtl/afifo_pkg.sv
// Shared async-FIFO definitions: default geometry and Gray/binary pointer conversions,
// used by both the write-side and read-side controllers.
package afifo_pkg;

  localparam int unsigned DEF_ADDR_W      = 4;
  localparam int unsigned DEF_SYNC_STAGES = 2;
  localparam int unsigned CODE_W          = 32;

  function automatic logic [CODE_W-1:0] bin2gray(input logic [CODE_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [CODE_W-1:0] gray2bin(input logic [CODE_W-1:0] g);
    logic [CODE_W-1:0] b;
    b[CODE_W-1] = g[CODE_W-1];
    for (int i = CODE_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/afifo_sync.sv
// Multi-flop synchronizer for a Gray-coded pointer crossing into this clock domain.
module afifo_sync #(
  parameter int unsigned WIDTH  = 5,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(STAGES); i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d;
      for (int i = 1; i < int'(STAGES); i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/afifo_wr_ctrl.sv
// Async FIFO write-side controller: write pointer, full/almost-full/level status.
// Define AFIFO_WR_OVF_EN to build the sticky write-overflow flag.
module afifo_wr_ctrl
  import afifo_pkg::*;
#(
  parameter int unsigned ADDR_W       = DEF_ADDR_W,
  parameter int unsigned SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter int unsigned AFULL_THRESH = (2 ** ADDR_W) - 2
) (
  input  logic              wclk,
  input  logic              wrst_n,
  input  logic              winc,
  input  logic [ADDR_W:0]   rptr_gray,
  input  logic              wclr_ovf,
  output logic [ADDR_W-1:0] waddr,
  output logic              wen,
  output logic [ADDR_W:0]   wptr_gray,
  output logic              wfull,
  output logic              walmost_full,
  output logic              woverflow,
  output logic [ADDR_W:0]   wlevel
);

  localparam int unsigned PTR_W = ADDR_W + 1;
  // Full when the write pointer is one lap ahead: Gray pointers differ in the top two bits only.
  localparam logic [PTR_W-1:0] FULL_MASK = PTR_W'(3) << (ADDR_W - 1);
  localparam logic [PTR_W-1:0] AFULL_LVL = PTR_W'(AFULL_THRESH);

  logic [PTR_W-1:0] wbin;
  logic [PTR_W-1:0] next_wbin;
  logic [PTR_W-1:0] next_wgray;
  logic [PTR_W-1:0] rptr_sync;
  logic [PTR_W-1:0] rbin_sync;
  logic [PTR_W-1:0] next_level;

  afifo_sync #(
    .WIDTH  (PTR_W),
    .STAGES (SYNC_STAGES)
  ) u_rptr_sync (
    .clk   (wclk),
    .rst_n (wrst_n),
    .d     (rptr_gray),
    .q     (rptr_sync)
  );

  assign wen   = winc & ~wfull;
  assign waddr = wbin[ADDR_W-1:0];

  // Next-state pointer arithmetic; all status is computed from the post-write pointer.
  always_comb begin
    next_wbin  = wbin + PTR_W'(wen);
    next_wgray = PTR_W'(bin2gray(CODE_W'(next_wbin)));
    rbin_sync  = PTR_W'(gray2bin(CODE_W'(rptr_sync)));
    next_level = next_wbin - rbin_sync;
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin         <= '0;
      wptr_gray    <= '0;
      wfull        <= 1'b0;
      walmost_full <= 1'b0;
      wlevel       <= '0;
    end else begin
      wbin         <= next_wbin;
      wptr_gray    <= next_wgray;
      wfull        <= (next_wgray == (rptr_sync ^ FULL_MASK));
      walmost_full <= (next_level >= AFULL_LVL);
      wlevel       <= next_level;
    end
  end

`ifdef AFIFO_WR_OVF_EN
  // Sticky overflow; a rejected write on the same edge as a clear keeps it set.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      woverflow <= 1'b0;
    end else if (winc && wfull) begin
      woverflow <= 1'b1;
    end else if (wclr_ovf) begin
      woverflow <= 1'b0;
    end
  end
`else
  logic unused_wclr_ovf;
  assign unused_wclr_ovf = wclr_ovf;
  assign woverflow       = 1'b0;
`endif

endmodule

// File: tb/tb_afifo_wr_ctrl.sv
// Self-checking bench for afifo_wr_ctrl (ADDR_W=3, SYNC_STAGES=2, AFULL_THRESH=6).
module tb_afifo_wr_ctrl;

  localparam int AW    = 3;
  localparam int SS    = 2;
  localparam int TH    = 6;
  localparam int DEPTH = 8;

  logic          wclk;
  logic          wrst_n;
  logic          winc;
  logic [AW:0]   rptr_gray;
  logic          wclr_ovf;
  logic [AW-1:0] waddr;
  logic          wen;
  logic [AW:0]   wptr_gray;
  logic          wfull;
  logic          walmost_full;
  logic          woverflow;
  logic [AW:0]   wlevel;

  afifo_wr_ctrl #(
    .ADDR_W       (AW),
    .SYNC_STAGES  (SS),
    .AFULL_THRESH (TH)
  ) dut (
    .wclk         (wclk),
    .wrst_n       (wrst_n),
    .winc         (winc),
    .rptr_gray    (rptr_gray),
    .wclr_ovf     (wclr_ovf),
    .waddr        (waddr),
    .wen          (wen),
    .wptr_gray    (wptr_gray),
    .wfull        (wfull),
    .walmost_full (walmost_full),
    .woverflow    (woverflow),
    .wlevel       (wlevel)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  int checks = 0;
  int errors = 0;

  // Reference model: total writes accepted, total reads done, per-edge read history.
  int wcnt;
  int rd_cnt;
  int rhist[$];
  bit full_m;
  bit ovf_m;
  int prev_gray;

  function automatic int gray4(input int v);
    int m;
    m = v % (2 * DEPTH);
    return (m ^ (m >> 1));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    wcnt      = 0;
    rd_cnt    = 0;
    rhist     = {};
    full_m    = 1'b0;
    ovf_m     = 1'b0;
    prev_gray = 0;
  endtask

  task automatic check_all_zero();
    check("rst_waddr", 32'(waddr), 0);
    check("rst_wen", 32'(wen), 0);
    check("rst_wptr_gray", 32'(wptr_gray), 0);
    check("rst_wfull", 32'(wfull), 0);
    check("rst_walmost_full", 32'(walmost_full), 0);
    check("rst_wlevel", 32'(wlevel), 0);
    check("rst_woverflow", 32'(woverflow), 0);
  endtask

  // One write-clock cycle: drive, check combinational outputs, clock, check registered outputs.
  task automatic step(input bit wi, input bit rd, input bit clr);
    bit wen_e;
    int vis;
    int lvl;
    int chg;
    winc     = wi;
    wclr_ovf = clr;
    if (rd && rd_cnt < wcnt) rd_cnt++;
    rptr_gray = 4'(gray4(rd_cnt));
    #2;
    wen_e = wi && !full_m;
    check("waddr", 32'(waddr), 32'(wcnt % DEPTH));
    check("wen", 32'(wen), 32'(wen_e));
    @(posedge wclk);
    rhist.push_back(rd_cnt);
`ifdef AFIFO_WR_OVF_EN
    if (wi && full_m) ovf_m = 1'b1;
    else if (clr) ovf_m = 1'b0;
`endif
    if (wen_e) wcnt++;
    vis    = (rhist.size() > SS) ? rhist[rhist.size() - 1 - SS] : 0;
    lvl    = wcnt - vis;
    full_m = (lvl == DEPTH);
    #1;
    check("wptr_gray", 32'(wptr_gray), 32'(gray4(wcnt)));
    check("wlevel", 32'(wlevel), 32'(lvl));
    check("wfull", 32'(wfull), 32'(full_m));
    check("walmost_full", 32'(walmost_full), 32'(lvl >= TH));
    check("woverflow", 32'(woverflow), 32'(ovf_m));
    chg = $countones(32'(wptr_gray) ^ 32'(prev_gray));
    check("gray_onebit", 32'(chg <= 1), 1);
    prev_gray = int'(wptr_gray);
  endtask

  initial begin
    wrst_n    = 1'b0;
    winc      = 1'b0;
    wclr_ovf  = 1'b0;
    rptr_gray = '0;
    reset_model();
    #12;
    check_all_zero();
    @(negedge wclk);
    wrst_n = 1'b1;

    // Fill from empty: addresses 0..7, Gray 1,3,2,6,7,5,4,12, almost-full at 6, full at 8.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b0);
    check("fill_level", 32'(wlevel), 8);
    check("fill_gray_last", 32'(wptr_gray), 12);

    // Writes against a full FIFO are rejected.
    repeat (3) step(1'b1, 1'b0, 1'b0);
    check("full_hold_waddr", 32'(waddr), 0);

    // One read releases full after the synchronizer delay; next write lands at address 0.
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("release_wfull", 32'(wfull), 0);
    check("release_level", 32'(wlevel), 7);
    step(1'b1, 1'b0, 1'b0);

    // Full again: set wins over a simultaneous clear, then a lone clear drops the flag.
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);

    // Drain, then stream 20 writes with the reader following in lockstep across the wrap.
    repeat (10) step(1'b0, 1'b1, 1'b0);
    repeat (4) step(1'b0, 1'b0, 1'b0);
    repeat (20) step(1'b1, 1'b1, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 200; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0));
    end

    // Clean restart, build level 5, then reset mid-burst.
    wrst_n    = 1'b0;
    winc      = 1'b0;
    wclr_ovf  = 1'b0;
    rptr_gray = '0;
    reset_model();
    @(negedge wclk);
    wrst_n = 1'b1;
    repeat (5) step(1'b1, 1'b0, 1'b0);
    check("pre_reset_level", 32'(wlevel), 5);
    wrst_n    = 1'b0;
    winc      = 1'b0;
    rptr_gray = '0;
    #1;
    check_all_zero();
    reset_model();
    @(negedge wclk);
    wrst_n = 1'b1;
    step(1'b1, 1'b0, 1'b0);
    repeat (3) step(1'b1, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
